mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arb_order_fifo.sv | 49 ++++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: requester IDs, access size codes,
// default order-FIFO depth and the lock-state encoding.
package mem_arbiter_pkg;

    localparam int DEFAULT_DEPTH = 2;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ARB_OPEN      = 2'd0,
        ARB_HOLD_INST = 2'd1,
        ARB_HOLD_DATA = 2'd2
    } arb_state_t;

    function automatic arb_state_t hold_state(input logic id);
        return (id == REQ_DATA) ? ARB_HOLD_DATA : ARB_HOLD_INST;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared downstream memory port.
// slave = arbiter view, master = the cores and memory around it.
interface mem_arbiter_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    logic [31:0] rsp_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, rsp_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, rsp_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_order_fifo.sv
// In-order record of which requester owns each outstanding transaction.
// The caller never pushes when full nor pops when empty.
module mem_arb_order_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] slots;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // DEPTH is a power of two, so the pointers wrap on natural overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slots  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= push_id;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = slots[rd_ptr];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto one pipelined memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking instead of fixed data priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus,
    output logic           err
);

    arb_state_t state, state_nxt;

    logic sel;
    logic sel_open;
    logic req_sel;
    logic mem_req_int;
    logic push;
    logic pop;
    logic full;
    logic empty;
    logic head;

`ifdef MEM_ARB_RR_EN
    logic last_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_acc <= REQ_INST;
        else if (push)
            last_acc <= sel;
    end

    // a tie goes to whoever was not accepted last; reset favours data
    always_comb begin
        if (bus.data_req && bus.inst_req)
            sel_open = (last_acc == REQ_DATA) ? REQ_INST : REQ_DATA;
        else
            sel_open = bus.data_req ? REQ_DATA : REQ_INST;
    end
`else
    assign sel_open = bus.data_req ? REQ_DATA : REQ_INST;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ARB_OPEN;
        else
            state <= state_nxt;
    end

    // an offered-but-refused request pins selection until memory takes it
    always_comb begin
        state_nxt = state;
        sel       = sel_open;
        case (state)
            ARB_HOLD_INST: sel = REQ_INST;
            ARB_HOLD_DATA: sel = REQ_DATA;
            default:       sel = sel_open;
        endcase

        req_sel     = (sel == REQ_DATA) ? bus.data_req : bus.inst_req;
        mem_req_int = req_sel && !full && !reset;
        push        = mem_req_int && bus.mem_addr_ok;

        case (state)
            ARB_OPEN: if (mem_req_int && !bus.mem_addr_ok) state_nxt = hold_state(sel);
            default:  if (push || !req_sel) state_nxt = ARB_OPEN;
        endcase
    end

    always_comb begin
        bus.mem_req   = mem_req_int;
        bus.mem_wr    = 1'b0;
        bus.mem_size  = 2'd0;
        bus.mem_wstrb = 4'd0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        if (!reset) begin
            if (sel == REQ_DATA) begin
                bus.mem_wr    = bus.data_wr;
                bus.mem_size  = bus.data_size;
                bus.mem_wstrb = bus.data_wstrb;
                bus.mem_addr  = bus.data_addr;
                bus.mem_wdata = bus.data_wdata;
            end else begin
                bus.mem_size  = SIZE_WORD;
                bus.mem_addr  = bus.inst_addr;
            end
        end
    end

    // a response never pairs with this cycle's acceptance: pop needs a prior entry
    assign pop              = bus.mem_data_ok && !empty;
    assign bus.inst_addr_ok = push && (sel == REQ_INST);
    assign bus.data_addr_ok = push && (sel == REQ_DATA);
    assign bus.inst_data_ok = pop && (head == REQ_INST);
    assign bus.data_data_ok = pop && (head == REQ_DATA);
    assign bus.rsp_rdata    = bus.mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if (bus.mem_data_ok && empty)
            err <= 1'b1;
    end

    mem_arb_order_fifo #(.DEPTH(DEPTH)) u_order (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_id (sel),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reset-state vectors, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int DEPTH = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err;

    mem_arbiter_if bus();

    mem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int q[$];
    bit m_lk;
    bit m_lk_id;
    bit m_last;

    typedef struct {
        logic       ireq;
        logic       dreq;
        logic       dwr;
        logic [1:0] dsize;
        logic       aok;
        logic       ereq;
        logic       esel;
        logic       eiaok;
        logic       edaok;
    } vec_t;

    vec_t vt[7];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.inst_req    = 1'b0;
        bus.inst_addr   = 32'd0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_size   = 2'd0;
        bus.data_wstrb  = 4'd0;
        bus.data_addr   = 32'd0;
        bus.data_wdata  = 32'd0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'd0;
    endtask

    task automatic rst_dut();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // accept one inst then one data transaction, leaving the FIFO full
    task automatic fill_two();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h100; bus.mem_addr_ok = 1'b1;
        tick();
        bus.inst_req = 1'b0; bus.data_req = 1'b1; bus.data_addr = 32'h200;
        tick();
        idle();
    endtask

    initial begin
        idle();
        // outputs while reset is held, with every input active
        bus.inst_req = 1'b1; bus.data_req = 1'b1; bus.data_addr = 32'h55;
        bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hA5A5_0001;
        #2;
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_iaok", bus.inst_addr_ok, 1'b0);
        chk1("rst_daok", bus.data_addr_ok, 1'b0);
        chk1("rst_idok", bus.inst_data_ok, 1'b0);
        chk1("rst_ddok", bus.data_data_ok, 1'b0);
        chk32("rst_mem_addr", bus.mem_addr, 32'd0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_rdata_fwd", bus.rsp_rdata, 32'hA5A5_0001);

        // single-cycle vectors from a fresh reset
        //        ireq dreq dwr dsize aok  ereq esel eiaok edaok
        vt[0] = '{1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[4] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[6] = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            rst_dut();
            bus.inst_req    = vt[i].ireq;
            bus.inst_addr   = 32'h0000_1000;
            bus.data_req    = vt[i].dreq;
            bus.data_wr     = vt[i].dwr;
            bus.data_size   = vt[i].dsize;
            bus.data_wstrb  = 4'hA;
            bus.data_addr   = 32'h0000_2000;
            bus.data_wdata  = 32'hCAFE_F00D;
            bus.mem_addr_ok = vt[i].aok;
            #1;
            chk1("tbl_mem_req", bus.mem_req, vt[i].ereq);
            chk1("tbl_iaok", bus.inst_addr_ok, vt[i].eiaok);
            chk1("tbl_daok", bus.data_addr_ok, vt[i].edaok);
            if (vt[i].ereq) begin
                chk32("tbl_addr", bus.mem_addr, vt[i].esel ? 32'h0000_2000 : 32'h0000_1000);
                chk1("tbl_wr", bus.mem_wr, vt[i].esel ? vt[i].dwr : 1'b0);
                chk32("tbl_size", 32'(bus.mem_size), vt[i].esel ? 32'(vt[i].dsize) : 32'd2);
                chk32("tbl_wstrb", 32'(bus.mem_wstrb), vt[i].esel ? 32'hA : 32'h0);
                chk32("tbl_wdata", bus.mem_wdata, vt[i].esel ? 32'hCAFE_F00D : 32'h0);
            end
        end

        // both requesting: data first, then inst (round-robin) or data again (fixed)
        rst_dut();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1000;
        bus.data_req = 1'b1; bus.data_addr = 32'h2000; bus.mem_addr_ok = 1'b1;
        #1;
        chk1("prio_c1_daok", bus.data_addr_ok, 1'b1);
        chk1("prio_c1_iaok", bus.inst_addr_ok, 1'b0);
        tick();
        bus.mem_data_ok = 1'b1;
        #1;
        chk1("prio_c2_ddok", bus.data_data_ok, 1'b1);
`ifdef MEM_ARB_RR_EN
        chk1("prio_c2_iaok", bus.inst_addr_ok, 1'b1);
        chk1("prio_c2_daok", bus.data_addr_ok, 1'b0);
`else
        chk1("starve_c2_daok", bus.data_addr_ok, 1'b1);
        chk1("starve_c2_iaok", bus.inst_addr_ok, 1'b0);
        tick();
        bus.mem_data_ok = 1'b0; bus.data_req = 1'b0;
        #1;
        chk1("starve_c3_iaok", bus.inst_addr_ok, 1'b1);
`endif

        // lock: refused inst request must not be preempted by a later data request
        rst_dut();
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0000;
        #1;
        chk32("lock_c0_addr", bus.mem_addr, 32'h1C00_0000);
        chk1("lock_c0_req", bus.mem_req, 1'b1);
        tick();
        #1;
        chk32("lock_c1_addr", bus.mem_addr, 32'h1C00_0000);
        tick();
        bus.data_req = 1'b1; bus.data_addr = 32'h0000_3000;
        #1;
        chk32("lock_c2_addr", bus.mem_addr, 32'h1C00_0000);
        chk1("lock_c2_daok", bus.data_addr_ok, 1'b0);
        tick();
        bus.mem_addr_ok = 1'b1;
        #1;
        chk32("lock_c3_addr", bus.mem_addr, 32'h1C00_0000);
        chk1("lock_c3_iaok", bus.inst_addr_ok, 1'b1);
        chk1("lock_c3_daok", bus.data_addr_ok, 1'b0);
        tick();
        bus.inst_req = 1'b0;
        #1;
        chk32("lock_c4_addr", bus.mem_addr, 32'h0000_3000);
        chk1("lock_c4_daok", bus.data_addr_ok, 1'b1);

        // in-order responses routed by owner
        rst_dut();
        fill_two();
        bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h1111_1111;
        #1;
        chk1("ord_r1_idok", bus.inst_data_ok, 1'b1);
        chk1("ord_r1_ddok", bus.data_data_ok, 1'b0);
        chk32("ord_r1_rdata", bus.rsp_rdata, 32'h1111_1111);
        tick();
        bus.mem_rdata = 32'h2222_2222;
        #1;
        chk1("ord_r2_idok", bus.inst_data_ok, 1'b0);
        chk1("ord_r2_ddok", bus.data_data_ok, 1'b1);
        chk32("ord_r2_rdata", bus.rsp_rdata, 32'h2222_2222);
        tick();
        bus.mem_data_ok = 1'b0;
        #1;
        chk1("ord_err", err, 1'b0);

        // full FIFO: no request even while a response frees a slot
        rst_dut();
        fill_two();
        bus.inst_req = 1'b1; bus.data_req = 1'b1; bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1;
        #1;
        chk1("full_req_low", bus.mem_req, 1'b0);
        chk1("full_pop_idok", bus.inst_data_ok, 1'b1);
        tick();
        bus.mem_data_ok = 1'b0;
        #1;
        chk1("full_req_next", bus.mem_req, 1'b1);

        // stray response
        rst_dut();
        bus.mem_data_ok = 1'b1;
        #1;
        chk1("stray_idok", bus.inst_data_ok, 1'b0);
        chk1("stray_ddok", bus.data_data_ok, 1'b0);
        tick();
        bus.mem_data_ok = 1'b0;
        #1;
        chk1("stray_err", err, 1'b1);
        tick();
        chk1("stray_err_sticky", err, 1'b1);
        reset = 1'b1;
        #1;
        chk1("stray_err_clr", err, 1'b0);
        tick();
        reset = 1'b0;

        // reset with two outstanding
        rst_dut();
        fill_two();
        reset = 1'b1;
        bus.inst_req = 1'b1; bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h77;
        bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1;
        #1;
        chk1("rst2_mem_req", bus.mem_req, 1'b0);
        chk1("rst2_daok", bus.data_addr_ok, 1'b0);
        chk1("rst2_ddok", bus.data_data_ok, 1'b0);
        chk1("rst2_idok", bus.inst_data_ok, 1'b0);
        chk1("rst2_wr", bus.mem_wr, 1'b0);
        chk32("rst2_addr", bus.mem_addr, 32'd0);
        tick();
        reset = 1'b0;
        idle();
        bus.mem_data_ok = 1'b1;
        #1;
        chk1("rst2_late_idok", bus.inst_data_ok, 1'b0);
        chk1("rst2_late_ddok", bus.data_data_ok, 1'b0);
        tick();
        bus.mem_data_ok = 1'b0;
        #1;
        chk1("rst2_late_err", err, 1'b1);

        // randomized run against the reference model
        rst_dut();
        q.delete();
        m_lk = 1'b0; m_lk_id = 1'b0; m_last = REQ_INST;
        for (int c = 0; c < 3000; c++) begin
            bit sel;
            bit ereq;
            bit acc;
            if (!bus.inst_req && $urandom_range(0, 2) != 0) begin
                bus.inst_req  = 1'b1;
                bus.inst_addr = $urandom;
            end
            if (!bus.data_req && $urandom_range(0, 2) == 0) begin
                bus.data_req   = 1'b1;
                bus.data_wr    = 1'($urandom_range(0, 1));
                bus.data_size  = 2'($urandom_range(0, 2));
                bus.data_wstrb = 4'($urandom);
                bus.data_addr  = $urandom;
                bus.data_wdata = $urandom;
            end
            bus.mem_addr_ok = 1'($urandom_range(0, 1));
            bus.mem_data_ok = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            bus.mem_rdata   = $urandom;

            if (m_lk)
                sel = m_lk_id;
            else if (bus.data_req && bus.inst_req)
                sel = RR ? !m_last : 1'b1;
            else
                sel = bus.data_req;
            ereq = (sel ? bus.data_req : bus.inst_req) && (q.size() < DEPTH);
            acc  = ereq && bus.mem_addr_ok;
            #1;
            chk1("rnd_mem_req", bus.mem_req, ereq);
            chk1("rnd_iaok", bus.inst_addr_ok, acc && !sel);
            chk1("rnd_daok", bus.data_addr_ok, acc && sel);
            if (ereq) begin
                chk32("rnd_addr", bus.mem_addr, sel ? bus.data_addr : bus.inst_addr);
                chk1("rnd_wr", bus.mem_wr, sel ? bus.data_wr : 1'b0);
                chk32("rnd_size", 32'(bus.mem_size), sel ? 32'(bus.data_size) : 32'd2);
                chk32("rnd_wstrb", 32'(bus.mem_wstrb), sel ? 32'(bus.data_wstrb) : 32'd0);
                chk32("rnd_wdata", bus.mem_wdata, sel ? bus.data_wdata : 32'd0);
            end
            chk1("rnd_idok", bus.inst_data_ok, bus.mem_data_ok && (q[0] == 0));
            chk1("rnd_ddok", bus.data_data_ok, bus.mem_data_ok && (q[0] == 1));
            chk32("rnd_rdata", bus.rsp_rdata, bus.mem_rdata);
            chk1("rnd_err", err, 1'b0);
            tick();
            if (bus.mem_data_ok)
                void'(q.pop_front());
            if (acc) begin
                q.push_back(int'(sel));
                m_last = sel;
                m_lk   = 1'b0;
                if (sel) bus.data_req = 1'b0;
                else     bus.inst_req = 1'b0;
            end else if (ereq) begin
                m_lk    = 1'b1;
                m_lk_id = sel;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
